// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin arbiter giving four CPUs fixed-latency access to one single-port SRAM.
// Optional Logic Analyzer requester with absolute priority when SHARED_MEM_LA_PORT_EN is defined.
module shared_mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic            soc_clk,
    input  logic            soc_rst,
    input  logic [3:0]      req_en,
    input  logic [3:0]      req_rw,
    input  logic [4*AW-1:0] req_addr,
    input  logic [4*DW-1:0] req_wdata,
    output logic [3:0]      ack,
    output logic [DW-1:0]   rdata,
    output logic            busy,
    output logic            en_to_memB,
    output logic            rw_to_mem,
    output logic [AW-1:0]   addr_to_mem,
    output logic [DW-1:0]   data_to_mem,
    input  logic [DW-1:0]   data_from_mem
`ifdef SHARED_MEM_LA_PORT_EN
    ,
    input  logic            la_req,
    input  logic            la_rw,
    input  logic [AW-1:0]   la_addr,
    input  logic [DW-1:0]   la_wdata,
    output logic            la_ack
`endif
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]    state;
    logic [1:0]    last_grant;
    logic [1:0]    idx;
    logic [1:0]    pick;
    logic          rw_q;
    logic          la_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          la_req_i;
    logic          la_rw_i;
    logic [AW-1:0] la_addr_i;
    logic [DW-1:0] la_wdata_i;

`ifdef SHARED_MEM_LA_PORT_EN
    assign la_req_i   = la_req;
    assign la_rw_i    = la_rw;
    assign la_addr_i  = la_addr;
    assign la_wdata_i = la_wdata;
    assign la_ack     = state == RESP && la_q;
`else
    assign la_req_i   = 1'b0;
    assign la_rw_i    = 1'b0;
    assign la_addr_i  = '0;
    assign la_wdata_i = '0;
`endif

    // Descending scan so the nearest requester after last_grant wins; k=4 wraps to last_grant itself.
    always_comb begin
        pick = last_grant;
        for (int k = 4; k >= 1; k--)
            if (req_en[last_grant + 2'(k)]) pick = last_grant + 2'(k);
    end

    always_ff @(posedge soc_clk) begin
        if (soc_rst) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            idx        <= 2'd0;
            rw_q       <= 1'b0;
            la_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else if (state == IDLE) begin
            if (la_req_i || |req_en) begin
                state   <= ACCESS;
                la_q    <= la_req_i;
                idx     <= pick;
                rw_q    <= la_req_i ? la_rw_i : req_rw[pick];
                addr_q  <= la_req_i ? la_addr_i : req_addr[pick*AW +: AW];
                wdata_q <= la_req_i ? la_wdata_i : req_wdata[pick*DW +: DW];
            end
        end else if (state == ACCESS) begin
            state <= RESP;
        end else begin
            state <= IDLE;
            if (!rw_q) rdata_q <= data_from_mem;
            if (!la_q) last_grant <= idx;
        end
    end

    assign busy        = state != IDLE;
    assign en_to_memB  = state != ACCESS;
    assign rw_to_mem   = state == ACCESS ? ~rw_q : 1'b1;
    assign addr_to_mem = addr_q;
    assign data_to_mem = wdata_q;
    assign ack         = (state == RESP && !la_q) ? 4'b0001 << idx : 4'b0000;
    // Read data arrives during RESP, so it is passed through in the ack cycle and held afterwards.
    assign rdata       = (state == RESP && !rw_q) ? data_from_mem : rdata_q;
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb_shared_mem_arbiter: directed and random checks of shared_mem_arbiter against a transaction-level model.
// Exercises the SHARED_MEM_LA_PORT_EN requester when that macro is defined.
module tb_shared_mem_arbiter;
    localparam int AW = 9;
    localparam int DW = 16;

    logic            soc_clk;
    logic            soc_rst;
    logic [3:0]      req_en;
    logic [3:0]      req_rw;
    logic [4*AW-1:0] req_addr;
    logic [4*DW-1:0] req_wdata;
    logic [3:0]      ack;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            en_to_memB;
    logic            rw_to_mem;
    logic [AW-1:0]   addr_to_mem;
    logic [DW-1:0]   data_to_mem;
    logic [DW-1:0]   data_from_mem;
`ifdef SHARED_MEM_LA_PORT_EN
    logic            la_req;
    logic            la_rw;
    logic [AW-1:0]   la_addr;
    logic [DW-1:0]   la_wdata;
    logic            la_ack;
`endif

    shared_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .soc_clk(soc_clk),
        .soc_rst(soc_rst),
        .req_en(req_en),
        .req_rw(req_rw),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .ack(ack),
        .rdata(rdata),
        .busy(busy),
        .en_to_memB(en_to_memB),
        .rw_to_mem(rw_to_mem),
        .addr_to_mem(addr_to_mem),
        .data_to_mem(data_to_mem),
        .data_from_mem(data_from_mem)
`ifdef SHARED_MEM_LA_PORT_EN
        ,
        .la_req(la_req),
        .la_rw(la_rw),
        .la_addr(la_addr),
        .la_wdata(la_wdata),
        .la_ack(la_ack)
`endif
    );

    initial begin
        soc_clk = 0;
        forever #5 soc_clk = ~soc_clk;
    end

    int n_chk = 0;
    int n_fail = 0;
    logic [DW-1:0] mem [512];
    logic [DW-1:0] ref_mem [512];
    int ack_log[$];
    int cyc, acc_cyc, ack_cyc, free_at, m_lg, e_id;
    logic e_la, e_rw;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, m_rdata;
    bit op_pend, op_w;
    logic [AW-1:0] op_addr;
    logic [DW-1:0] op_data;
    int post[4];
    int la_post;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(input int lg, input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(lg + k) % 4]) return (lg + k) % 4;
        return -1;
    endfunction

    // One cycle: check this cycle's outputs against the model, advance the model, then cross the edge.
    task automatic tick();
        bit in_acc, in_ack, any;
        @(negedge soc_clk);
        in_acc = cyc == acc_cyc;
        in_ack = cyc == ack_cyc;
        if (in_acc && e_rw) ref_mem[e_addr] = e_wdata;
        if (in_ack && !e_rw) m_rdata = ref_mem[e_addr];
        check("busy", busy, in_acc || in_ack);
        check("en_to_memB", en_to_memB, !in_acc);
        check("rw_to_mem", rw_to_mem, in_acc ? !e_rw : 1'b1);
        if (in_acc) begin
            check("addr_to_mem", addr_to_mem, e_addr);
            check("data_to_mem", data_to_mem, e_wdata);
        end
        check("ack", ack, (in_ack && !e_la) ? 32'(1 << e_id) : 32'd0);
        check("rdata", rdata, m_rdata);
`ifdef SHARED_MEM_LA_PORT_EN
        check("la_ack", la_ack, in_ack && e_la);
`endif
        for (int i = 0; i < 4; i++) if (ack[i]) ack_log.push_back(i);
        if (in_ack && !e_la) m_lg = e_id;
        if (!en_to_memB) begin
            op_pend = 1; op_w = !rw_to_mem; op_addr = addr_to_mem; op_data = data_to_mem;
        end
        any = |req_en;
`ifdef SHARED_MEM_LA_PORT_EN
        any = any || la_req;
`endif
        if (soc_rst) begin
            acc_cyc = -1; ack_cyc = -1; free_at = cyc + 1; m_lg = 3; m_rdata = '0;
        end else if (cyc >= free_at && any) begin
            acc_cyc = cyc + 1; ack_cyc = cyc + 2; free_at = cyc + 3;
`ifdef SHARED_MEM_LA_PORT_EN
            if (la_req) begin
                e_la = 1; e_rw = la_rw; e_addr = la_addr; e_wdata = la_wdata;
            end else
`endif
            begin
                e_la = 0;
                e_id = rr_pick(m_lg, req_en);
                e_rw = req_rw[e_id];
                e_addr = req_addr[e_id*AW +: AW];
                e_wdata = req_wdata[e_id*DW +: DW];
            end
        end
        @(posedge soc_clk);
        #1;
        cyc++;
        if (op_pend) begin
            if (op_w) mem[op_addr] = op_data;
            else data_from_mem = mem[op_addr];
            op_pend = 0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic new_payload(input int i);
        req_rw[i] = 1'($urandom);
        req_addr[i*AW +: AW] = 9'($urandom_range(15));
        req_wdata[i*DW +: DW] = 16'($urandom);
    endtask

    // Random requesters obey the hold-until-ack protocol; after an ack they drop, linger one cycle, or re-request.
    task automatic drive();
        soc_rst = 0;
        for (int i = 0; i < 4; i++) begin
            if (cyc == ack_cyc && !e_la && e_id == i) begin
                post[i] = $urandom_range(2);
                if (post[i] == 0) req_en[i] = 0;
            end else if (post[i] != 0) begin
                if (post[i] == 1) req_en[i] = 0;
                else new_payload(i);
                post[i] = 0;
            end else if (!req_en[i] && $urandom_range(3) == 0) begin
                req_en[i] = 1;
                new_payload(i);
            end
        end
`ifdef SHARED_MEM_LA_PORT_EN
        if (cyc == ack_cyc && e_la) la_req = 0;
        else if (!la_req && $urandom_range(15) == 0) begin
            la_req = 1; la_rw = 1'($urandom); la_addr = 9'($urandom_range(15)); la_wdata = 16'($urandom);
        end
`endif
        if (cyc == acc_cyc && $urandom_range(15) == 0) soc_rst = 1;
    endtask

    task automatic check_log(input string tag, input int exp[$]);
        check({tag, "_count"}, ack_log.size(), exp.size());
        for (int k = 0; k < exp.size() && k < ack_log.size(); k++)
            check({tag, "_order"}, ack_log[k], exp[k]);
        ack_log.delete();
    endtask

    initial begin
        for (int a = 0; a < 512; a++) begin
            mem[a] = 16'($urandom);
            ref_mem[a] = mem[a];
        end
        mem[5] = 16'hBEEF;
        ref_mem[5] = 16'hBEEF;
        data_from_mem = '0;
        req_en = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
`ifdef SHARED_MEM_LA_PORT_EN
        la_req = 0; la_rw = 0; la_addr = '0; la_wdata = '0;
`endif
        for (int i = 0; i < 4; i++) post[i] = 0;
        la_post = 0;
        soc_rst = 1;
        repeat (2) @(posedge soc_clk);
        #1;
        soc_rst = 0;
        cyc = 0; acc_cyc = -1; ack_cyc = -1; free_at = 0; m_lg = 3; m_rdata = '0;
        e_id = 0; e_la = 0; e_rw = 0; e_addr = '0; e_wdata = '0; op_pend = 0;
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 0);
        check("rst_en", en_to_memB, 1);
        check("rst_rw", rw_to_mem, 1);
        check("rst_addr", addr_to_mem, 0);
        check("rst_data", data_to_mem, 0);

        // single read of word 5
        req_en = 4'b0001; req_rw = 4'b0000; req_addr[0 +: AW] = 9'h005;
        run(3);
        req_en = 0;
        run(1);
        check("read_hold", rdata, 16'hBEEF);
        check_log("single", '{0});

        // all four writing, fresh priority
        soc_rst = 1; tick(); soc_rst = 0;
        req_rw = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*AW +: AW] = 9'(i);
            req_wdata[i*DW +: DW] = 16'(16'h1000 + i);
        end
        req_en = 4'b1111;
        run(15);
        req_en = 0;
        run(1);
        check_log("rr4", '{0, 1, 2, 3, 0});
        for (int i = 0; i < 4; i++) check("mem_word", mem[i], 16'(16'h1000 + i));

        // last grant 1, then 3 must beat 0
        req_rw = 0; req_en = 4'b0010;
        run(3);
        req_en = 0;
        run(1);
        ack_log.delete();
        req_en = 4'b1001;
        run(3);
        req_en = 4'b0001;
        run(3);
        req_en = 0;
        run(1);
        check_log("wrap", '{3, 0});

        // reset during ACCESS of requester 2
        req_en = 4'b0100;
        tick();
        soc_rst = 1;
        tick();
        soc_rst = 0;
        req_en = 4'b0101;
        run(3);
        req_en = 4'b0100;
        run(3);
        req_en = 0;
        run(1);
        check_log("reset_abort", '{0, 2});

        // requester 1 drops during its RESP
        req_en = 4'b0010;
        run(2);
        req_en = 0;
        run(4);
        check_log("drop_resp", '{1});

`ifdef SHARED_MEM_LA_PORT_EN
        la_req = 1; la_rw = 0; la_addr = 9'h005; req_en = 4'b0100;
        run(3);
        la_req = 0;
        run(3);
        req_en = 0;
        run(1);
        check_log("la_first", '{2});
`endif

        for (int n = 0; n < 800; n++) begin
            drive();
            tick();
        end
        soc_rst = 0; req_en = 0;
`ifdef SHARED_MEM_LA_PORT_EN
        la_req = 0;
`endif
        run(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
